// File: rtl/asrm_bus_arbiter.sv
// asrm_bus_arbiter
// Two-requester arbiter for a single shared peripheral bus.
// Round-robin tie break: the requester that was not granted last wins.
// The grant is registered. Bus signals and read data follow the owner combinationally.
//
// Optional feature: define ASRM_ARB_TIMEOUT_EN to compile in a hold counter.
// With it, a waiting requester preempts the owner after max_hold cycles.
// Without it, the owner keeps the bus for as long as it requests it.
//
// Parameters
//   word_size      : data bus width
//   base_addr_size : address bus width
//   max_hold       : longest grant while the other side waits, 2..255
//                    (used only with ASRM_ARB_TIMEOUT_EN)
// Ports
//   clk                     : clock, rising edge
//   reset                   : asynchronous, active-low reset
//   req_a/req_b             : access requests
//   addr_a/addr_b           : requester addresses
//   write_en_a/write_en_b   : requester write strobes
//   wdata_a/wdata_b         : requester write data
//   grant_a/grant_b         : registered grants, never both high
//   rdata_a/rdata_b         : read data, zero unless that requester owns the bus
//   enable, write_en, addr, data_in : shared peripheral bus, zero when idle
//   data_out                : OR-combined peripheral read data
module asrm_bus_arbiter #(
  parameter int word_size      = 16,
  parameter int base_addr_size = 16,
  parameter int max_hold       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_a,
  input  logic                      req_b,
  input  logic [base_addr_size-1:0] addr_a,
  input  logic [base_addr_size-1:0] addr_b,
  input  logic                      write_en_a,
  input  logic                      write_en_b,
  input  logic [word_size-1:0]      wdata_a,
  input  logic [word_size-1:0]      wdata_b,
  output logic                      grant_a,
  output logic                      grant_b,
  output logic [word_size-1:0]      rdata_a,
  output logic [word_size-1:0]      rdata_b,
  output logic                      enable,
  output logic                      write_en,
  output logic [base_addr_size-1:0] addr,
  output logic [word_size-1:0]      data_in,
  input  logic [word_size-1:0]      data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t state_reg, state_next;
  // 1 = B was granted last. The reset value is B, so A wins the first tie.
  logic   last_owner_b_reg;
  logic   preempt_a, preempt_b;

`ifdef ASRM_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(max_hold - 1);
  logic [7:0] hold_cnt_reg;

  assign preempt_a = (state_reg == OWN_A) && req_b && (hold_cnt_reg == HOLD_LIMIT);
  assign preempt_b = (state_reg == OWN_B) && req_a && (hold_cnt_reg == HOLD_LIMIT);

  // Counts only the cycles during which the other side is kept waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_reg <= 8'd0;
    end else if ((state_next != state_reg) && (state_next != IDLE)) begin
      hold_cnt_reg <= 8'd0;
    end else if (((state_reg == OWN_A) && req_b) || ((state_reg == OWN_B) && req_a)) begin
      if (hold_cnt_reg != 8'hFF) begin
        hold_cnt_reg <= hold_cnt_reg + 8'd1;
      end
    end
  end
`else
  assign preempt_a = 1'b0;
  assign preempt_b = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      last_owner_b_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        if (state_next == OWN_A) begin
          last_owner_b_reg <= 1'b0;
        end else if (state_next == OWN_B) begin
          last_owner_b_reg <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_a && req_b) begin
          state_next = last_owner_b_reg ? OWN_A : OWN_B;
        end else if (req_a) begin
          state_next = OWN_A;
        end else if (req_b) begin
          state_next = OWN_B;
        end
      end
      // On release the bus goes straight to a waiting requester, with no idle cycle.
      OWN_A: begin
        if (!req_a) begin
          state_next = req_b ? OWN_B : IDLE;
        end else if (preempt_a) begin
          state_next = OWN_B;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_next = req_a ? OWN_A : IDLE;
        end else if (preempt_b) begin
          state_next = OWN_A;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant_a = (state_reg == OWN_A);
  assign grant_b = (state_reg == OWN_B);

  // Bus mux. The outputs are derived from the state register, so an
  // asynchronous reset drops the access at once.
  always_comb begin
    enable   = 1'b0;
    write_en = 1'b0;
    addr     = '0;
    data_in  = '0;
    rdata_a  = '0;
    rdata_b  = '0;
    case (state_reg)
      OWN_A: begin
        enable   = req_a;
        write_en = write_en_a;
        addr     = addr_a;
        data_in  = wdata_a;
        rdata_a  = data_out;
      end
      OWN_B: begin
        enable   = req_b;
        write_en = write_en_b;
        addr     = addr_b;
        data_in  = wdata_b;
        rdata_b  = data_out;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/asrm_bus_arbiter.md
ASRM_BUS_ARBITER -- requirements
Module: asrm_bus_arbiter

Interface
REQ-001 SHALL have parameter word_size, default 16, data bus width.
REQ-002 SHALL have parameter base_addr_size, default 16, address bus width.
REQ-003 SHALL have parameter max_hold, default 8, maximum grant length in cycles while the other requester waits (range 2..255).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_a, req_b  input  1  access request from requester A / B.
REQ-007 SHALL have ports addr_a, addr_b  input  base_addr_size  requester address.
REQ-008 SHALL have ports write_en_a, write_en_b  input  1  requester write strobe.
REQ-009 SHALL have ports wdata_a, wdata_b  input  word_size  requester write data.
REQ-010 SHALL have ports grant_a, grant_b  output  1  registered grant.
REQ-011 SHALL have ports rdata_a, rdata_b  output  word_size  read data returned to requester.
REQ-012 SHALL have ports enable, write_en  output  1; addr  output  base_addr_size; data_in  output  word_size: shared peripheral bus.
REQ-013 SHALL have port data_out  input  word_size  OR-combined peripheral read data.

Function
REQ-014 SHALL implement FSM states IDLE, OWN_A, OWN_B; grant_a=1 exactly in OWN_A, grant_b=1 exactly in OWN_B; never both.
REQ-015 IDLE: SHALL go to OWN_A or OWN_B on next edge if the respective req is high; if both high, SHALL pick the requester not granted last (last_owner register, reset value B, so A wins first).
REQ-016 OWN_x: SHALL stay while req_x=1 and not preempted; on req_x=0 SHALL move directly to OWN_y if req_y=1, else IDLE (one-cycle release, no dead cycle).
REQ-017 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to grant high.
REQ-018 In OWN_x, enable SHALL equal req_x and addr, write_en, data_in SHALL combinationally follow requester x; otherwise enable, write_en, addr, data_in SHALL be 0.
REQ-019 rdata_x SHALL equal data_out in OWN_x, 0 otherwise.
REQ-020 last_owner SHALL update on every entry into OWN_A/OWN_B.
REQ-021 A requester dropping req without being granted SHALL be ignored; no request is queued.

Reset
REQ-022 On reset low, SHALL asynchronously enter IDLE, set hold counter 0, last_owner=B; grant_a=grant_b=0, enable=write_en=0, addr=0, data_in=0, rdata_a=rdata_b=0.
REQ-023 Reset asserted mid-grant SHALL drop the grant immediately without completing the access; after release, first rising edge re-arbitrates from IDLE.

Configuration
REQ-024 Macro ASRM_ARB_TIMEOUT_EN SHALL compile in an 8-bit hold counter: cleared on entering OWN_x, incremented each cycle in OWN_x while req_y=1, saturating.
REQ-025 With ASRM_ARB_TIMEOUT_EN, when counter reaches max_hold-1 with req_y=1, next edge SHALL move OWN_x -> OWN_y even if req_x=1; the counter SHALL NOT count when req_y=0.
REQ-026 Without ASRM_ARB_TIMEOUT_EN, no counter SHALL exist and OWN_x SHALL persist while req_x=1 regardless of req_y; max_hold unused.

Verification
REQ-027 Reset low then high, req_a=1 at cycle 0 -> grant_a=1 at cycle 1, enable=1, addr=addr_a=16'hFF00, grant_b=0.
REQ-028 req_a=req_b=1 same cycle from IDLE after reset -> grant_a first; A drops req -> grant_b next cycle with no IDLE cycle; both re-request from IDLE later -> A granted (last_owner=B).
REQ-029 OWN_B, write_en_b=1, wdata_b=16'h00A5, addr_b=16'hFF01 -> bus write_en=1, data_in=16'h00A5, addr=16'hFF01; rdata_a=0, rdata_b=data_out.
REQ-030 With ASRM_ARB_TIMEOUT_EN, max_hold=8, A holds req, B requests at cycle t -> grant moves to B at cycle t+8; same stimulus without macro -> A keeps grant indefinitely.
REQ-031 Reset pulled low while grant_a=1 and write_en=1 -> grant_a, enable, write_en go 0 without a clock edge; release with req_b=1 -> grant_b after 1 cycle.
